// File: rtl/match_sweep_pkg.sv
// Shared types and widths for the match-unit sweep sequencer.
package match_sweep_pkg;

    localparam int TT_W  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_e;

endpackage

// File: rtl/match_sweep_if.sv
// Board/match-unit side signals of the sweep sequencer.
interface match_sweep_if
    import match_sweep_pkg::*;
();
    logic            START;
    logic            ABORT;
    logic            Y_IN;
    logic            A;
    logic            B;
    logic            C;
    logic [TT_W-1:0] TT;
    logic            BUSY;
    logic            DONE;
    logic            MISMATCH;

    modport master (
        input  START, ABORT, Y_IN,
        output A, B, C, TT, BUSY, DONE, MISMATCH
    );

    modport slave (
        output START, ABORT, Y_IN,
        input  A, B, C, TT, BUSY, DONE, MISMATCH
    );
endinterface

// File: rtl/match_settle_cnt.sv
// Loadable 4-bit settle down-counter; stops at zero.
module match_settle_cnt
    import match_sweep_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/match_sweep_ctrl.sv
// Steps A/B/C through all 8 vectors, captures Y into TT, checks it.
module match_sweep_ctrl
    import match_sweep_pkg::*;
#(
    parameter int unsigned     SETTLE_CYC = 2,
    parameter logic [TT_W-1:0] EXPECT     = 8'hE8
) (
    input  logic          CLK,
    input  logic          RST,
    match_sweep_if.master bus
);

    localparam logic [IDX_W-1:0] LAST = '1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mism_q, mism_d;
    logic             cnt_load;
    logic             cnt_zero;

    match_settle_cnt u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mism_q  <= mism_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ABORT) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, FIN: if (bus.START) state_d = SETTLE;
                SETTLE:    if (cnt_zero) state_d = SAMPLE;
                SAMPLE:    state_d = (idx_q == LAST) ? FIN : SETTLE;
            endcase
        end
    end

    // Last sample compares with the bit being written this same cycle.
    always_comb begin
        idx_d    = idx_q;
        tt_d     = tt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        mism_d   = mism_q;
        cnt_load = 1'b0;
        if (bus.ABORT) begin
            idx_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b0;
            mism_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, FIN: begin
                    if (bus.START) begin
                        idx_d    = '0;
                        tt_d     = '0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        mism_d   = 1'b0;
                        cnt_load = 1'b1;
                    end
                end
                SETTLE: begin
                end
                SAMPLE: begin
                    tt_d[idx_q] = bus.Y_IN;
                    if (idx_q == LAST) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        mism_d = ({bus.Y_IN, tt_q[TT_W-2:0]} != EXPECT);
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.A        = idx_q[2];
    assign bus.B        = idx_q[1];
    assign bus.C        = idx_q[0];
    assign bus.TT       = tt_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.MISMATCH = mism_q;

endmodule
